mem_stage: RTL and testbench

//  Pipeline stage 4. Consumes EX_MEM_* and runs loads/stores on the data-memory req/gnt/rvalid bus.

---
 rtl/mem_stage.sv | 169 ++++++++++++++++
 tb/tb_mem_stage.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage; runs loads/stores over the req/gnt/rvalid data bus and drives MEM_WB_*.
// Optional macro MEM_MISALIGN_TRAP_EN: misaligned H/W accesses trap instead of reaching the bus.
module mem_stage (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        hazard_stall,
    input  logic        hazard_flush,
    input  logic        EX_MEM_enable_out,
    input  logic [31:0] EX_MEM_PC,
    input  logic [31:0] EX_MEM_ALUResult,
    input  logic [31:0] EX_MEM_WriteData,
    input  logic [4:0]  EX_MEM_Rd,
    input  logic        EX_MEM_RegWrite,
    input  logic        EX_MEM_MemToReg,
    input  logic        EX_MEM_MemRead,
    input  logic        EX_MEM_MemWrite,
    input  logic [2:0]  EX_MEM_Funct3,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        mem_misalign,
    output logic        MEM_WB_enable_out,
    output logic [31:0] MEM_WB_PC,
    output logic [31:0] MEM_WB_ReadData,
    output logic [31:0] MEM_WB_ALUResult,
    output logic [4:0]  MEM_WB_Rd,
    output logic        MEM_WB_RegWrite,
    output logic        MEM_WB_MemToReg
);
    typedef enum logic [1:0] {IDLE, REQ, RESP, HOLD} state_t;
    typedef struct packed {
        logic        en;
        logic [31:0] pc;
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        rw;
        logic        m2r;
    } wb_t;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        rw;
        logic        m2r;
        logic        ld;
        logic [2:0]  f3;
    } op_t;

    state_t      state, state_n;
    wb_t         wb, wb_n, hold_q, hold_n, res;
    op_t         op, op_n;
    logic        squash, squash_n, mis_q, mis_n, req_n;
    logic        mem_op, mis, go, done;
    logic [1:0]  a, f;
    logic [7:0]  lb;
    logic [15:0] lh;
    logic [31:0] ext;

    assign a      = EX_MEM_ALUResult[1:0];
    assign f      = EX_MEM_Funct3[1:0];
    assign mem_op = EX_MEM_enable_out && (EX_MEM_MemRead || EX_MEM_MemWrite);
`ifdef MEM_MISALIGN_TRAP_EN
    assign mis = mem_op && (f == 2'b01 ? a[0] : (f == 2'b10 && a != 2'b00));
`else
    assign mis = 1'b0;
`endif
    assign go   = state == IDLE && mem_op && !hazard_stall && !hazard_flush && !mis;
    assign done = (state == REQ && dmem_gnt && dmem_we) || (state == RESP && dmem_rvalid);
    // A trapped access completes in one cycle, so it must not hold EX_MEM.
    assign mem_stall = (state == IDLE && mem_op && !mis) || (state == REQ && !(dmem_gnt && dmem_we)) ||
                       (state == RESP && !dmem_rvalid) || (state == HOLD && hazard_stall);
    assign mem_misalign = mis_q;

    assign lb  = dmem_rdata[{op.alu[1:0], 3'b000} +: 8];
    assign lh  = op.alu[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    assign ext = op.f3[1:0] == 2'b00 ? {{24{~op.f3[2] & lb[7]}}, lb} :
                 op.f3[1:0] == 2'b01 ? {{16{~op.f3[2] & lh[15]}}, lh} : dmem_rdata;
    assign res = wb_t'{en: 1'b1, pc: op.pc, rdata: op.ld ? ext : 32'd0, alu: op.alu,
                       rd: op.rd, rw: op.rw, m2r: op.m2r};

    assign {MEM_WB_enable_out, MEM_WB_PC, MEM_WB_ReadData, MEM_WB_ALUResult,
            MEM_WB_Rd, MEM_WB_RegWrite, MEM_WB_MemToReg} = wb;

    always_comb begin
        state_n  = state;
        wb_n     = wb;
        hold_n   = hold_q;
        op_n     = op;
        squash_n = squash;
        req_n    = dmem_req;
        mis_n    = 1'b0;
        if (state == IDLE) begin
            if (hazard_flush) wb_n = '0;
            else if (!hazard_stall) begin
                wb_n = EX_MEM_enable_out && !mem_op ?
                       wb_t'{1'b1, EX_MEM_PC, 32'd0, EX_MEM_ALUResult, EX_MEM_Rd, EX_MEM_RegWrite, EX_MEM_MemToReg} : '0;
                if (mis) begin
                    wb_n  = wb_t'{1'b1, EX_MEM_PC, 32'd0, EX_MEM_ALUResult, EX_MEM_Rd, 1'b0, EX_MEM_MemToReg};
                    mis_n = 1'b1;
                end
            end
            if (go) begin
                state_n  = REQ;
                req_n    = 1'b1;
                squash_n = 1'b0;
                op_n     = op_t'{pc: EX_MEM_PC, alu: EX_MEM_ALUResult, rd: EX_MEM_Rd, rw: EX_MEM_RegWrite,
                                 m2r: EX_MEM_MemToReg, ld: EX_MEM_MemRead, f3: EX_MEM_Funct3};
            end
        end else if (state == HOLD) begin
            if (hazard_flush || !hazard_stall) begin
                state_n = IDLE;
                wb_n    = hazard_flush ? '0 : hold_q;
            end
        end else begin
            // A flushed transaction still runs to completion on the bus; only its result is dropped.
            squash_n = squash || hazard_flush;
            wb_n     = hazard_stall && !hazard_flush ? wb : '0;
            if (state == REQ && dmem_gnt) begin
                req_n   = 1'b0;
                state_n = dmem_we ? IDLE : RESP;
            end
            if (done) begin
                state_n = IDLE;
                if (!squash_n && hazard_stall) begin
                    hold_n  = res;
                    state_n = HOLD;
                end else if (!squash_n) wb_n = res;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            wb         <= '0;
            hold_q     <= '0;
            op         <= '0;
            squash     <= 1'b0;
            mis_q      <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_be    <= '0;
        end else begin
            state    <= state_n;
            wb       <= wb_n;
            hold_q   <= hold_n;
            op       <= op_n;
            squash   <= squash_n;
            mis_q    <= mis_n;
            dmem_req <= req_n;
            if (go) begin
                dmem_we    <= EX_MEM_MemWrite;
                dmem_addr  <= {EX_MEM_ALUResult[31:2], 2'b00};
                dmem_be    <= f == 2'b00 ? 4'b0001 << a : f == 2'b01 ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
                dmem_wdata <= f == 2'b00 ? {4{EX_MEM_WriteData[7:0]}} :
                              f == 2'b01 ? {2{EX_MEM_WriteData[15:0]}} : EX_MEM_WriteData;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed checks of mem_stage ALU pass-through, loads, stores, HOLD, flush and misalign handling.
module tb_mem_stage;
    logic        clk = 1'b0, reset_n = 1'b0, hazard_stall = 1'b0, hazard_flush = 1'b0;
    logic        en = 1'b0, rw = 1'b0, m2r = 1'b0, mr = 1'b0, mw = 1'b0;
    logic [31:0] pc = '0, alu = '0, wd = '0, rdata = '0;
    logic [4:0]  rd = '0;
    logic [2:0]  f3 = '0;
    logic        gnt = 1'b0, rvalid = 1'b0;
    logic        req, we, stall, misal, wb_en, wb_rw, wb_m2r;
    logic [31:0] addr, wdata, wb_pc, wb_rdata, wb_alu;
    logic [3:0]  be;
    logic [4:0]  wb_rd;
    int total = 0, bad = 0;

    mem_stage dut (
        .clk(clk), .reset_n(reset_n), .hazard_stall(hazard_stall), .hazard_flush(hazard_flush),
        .EX_MEM_enable_out(en), .EX_MEM_PC(pc), .EX_MEM_ALUResult(alu), .EX_MEM_WriteData(wd),
        .EX_MEM_Rd(rd), .EX_MEM_RegWrite(rw), .EX_MEM_MemToReg(m2r), .EX_MEM_MemRead(mr),
        .EX_MEM_MemWrite(mw), .EX_MEM_Funct3(f3), .dmem_req(req), .dmem_we(we), .dmem_addr(addr),
        .dmem_wdata(wdata), .dmem_be(be), .dmem_gnt(gnt), .dmem_rvalid(rvalid), .dmem_rdata(rdata),
        .mem_stall(stall), .mem_misalign(misal), .MEM_WB_enable_out(wb_en), .MEM_WB_PC(wb_pc),
        .MEM_WB_ReadData(wb_rdata), .MEM_WB_ALUResult(wb_alu), .MEM_WB_Rd(wb_rd),
        .MEM_WB_RegWrite(wb_rw), .MEM_WB_MemToReg(wb_m2r)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic e, input logic [31:0] p, input logic [31:0] al, input logic [31:0] w,
                          input logic [4:0] r, input logic regw, input logic mtr, input logic rdm,
                          input logic wrm, input logic [2:0] fn);
        en = e; pc = p; alu = al; wd = w; rd = r; rw = regw; m2r = mtr; mr = rdm; mw = wrm; f3 = fn;
    endtask

    task automatic clr;
        set_op(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    endtask

    initial begin
        repeat (2) tick;
        check("rst_wb_en", wb_en, 0);
        check("rst_req", req, 0);
        check("rst_stall", stall, 0);
        check("rst_misal", misal, 0);
        reset_n = 1'b1;
        tick;

        // ALU op: one-cycle pass-through
        set_op(1, 32'h40, 32'h1234, 0, 5, 1, 0, 0, 0, 3'b000);
        #1 check("alu_stall", stall, 0);
        tick; clr;
        check("alu_en", wb_en, 1);
        check("alu_rw", wb_rw, 1);
        check("alu_rd", wb_rd, 5);
        check("alu_res", wb_alu, 32'h1234);
        check("alu_pc", wb_pc, 32'h40);
        check("alu_rdata", wb_rdata, 0);
        check("alu_stall2", stall, 0);

        // LB 0x103, gnt on the 2nd REQ cycle
        set_op(1, 32'h44, 32'h103, 0, 7, 1, 1, 1, 0, 3'b000);
        #1 check("lb_stall_idle", stall, 1);
        tick;
        check("lb_req", req, 1);
        check("lb_addr", addr, 32'h100);
        check("lb_we", we, 0);
        check("lb_bubble", wb_en, 0);
        check("lb_stall_req", stall, 1);
        tick;
        gnt = 1;
        #1 check("lb_stall_gnt", stall, 1);
        check("lb_req2", req, 1);
        tick; gnt = 0;
        check("lb_req_drop", req, 0);
        check("lb_stall_resp", stall, 1);
        tick;
        rvalid = 1; rdata = 32'h80123456;
        #1 check("lb_stall_rv", stall, 0);
        tick; rvalid = 0; clr;
        check("lb_en", wb_en, 1);
        check("lb_rdata", wb_rdata, 32'hFFFFFF80);
        check("lb_rd", wb_rd, 7);
        check("lb_m2r", wb_m2r, 1);

        // SH 0x102 data 0xBEEF
        set_op(1, 32'h48, 32'h102, 32'h0000BEEF, 0, 0, 0, 0, 1, 3'b001);
        tick;
        check("sh_be", be, 4'b1100);
        check("sh_wdata", wdata, 32'hBEEFBEEF);
        check("sh_we", we, 1);
        check("sh_req", req, 1);
        check("sh_stall", stall, 1);
        gnt = 1;
        #1 check("sh_stall_gnt", stall, 0);
        tick; gnt = 0; clr;
        check("sh_req_drop", req, 0);
        check("sh_en", wb_en, 1);
        check("sh_rw", wb_rw, 0);

        // LW completing under hazard_stall -> HOLD
        set_op(1, 32'h4C, 32'h200, 0, 9, 1, 1, 1, 0, 3'b010);
        tick; gnt = 1;
        tick; gnt = 0;
        rvalid = 1; rdata = 32'hCAFEF00D; hazard_stall = 1;
        #1 check("lw_stall_done", stall, 0);
        tick; rvalid = 0; clr;
        check("hold_stall1", stall, 1);
        check("hold_en1", wb_en, 0);
        tick;
        check("hold_stall2", stall, 1);
        hazard_stall = 0;
        #1 check("hold_release", stall, 0);
        check("hold_en2", wb_en, 0);
        tick;
        check("lw_en", wb_en, 1);
        check("lw_rdata", wb_rdata, 32'hCAFEF00D);
        check("lw_rd", wb_rd, 9);

        // Flush in RESP: bus completes, result discarded
        set_op(1, 32'h50, 32'h302, 0, 3, 1, 1, 1, 0, 3'b001);
        tick; gnt = 1;
        tick; gnt = 0; hazard_flush = 1;
        #1 check("fl_stall", stall, 1);
        tick; hazard_flush = 0;
        rvalid = 1; rdata = 32'h80010000;
        #1 check("fl_stall_rv", stall, 0);
        tick; rvalid = 0; clr;
        check("fl_en", wb_en, 0);
        check("fl_rw", wb_rw, 0);
        check("fl_req", req, 0);
        set_op(1, 32'h54, 32'h55, 0, 1, 1, 0, 0, 0, 3'b000);
        tick;
        check("post_fl_alu", wb_alu, 32'h55);
        check("post_fl_en", wb_en, 1);
        hazard_flush = 1;
        tick; hazard_flush = 0; clr;
        check("idle_flush_en", wb_en, 0);

        // LHU 0x306 (upper half, zero extend)
        set_op(1, 32'h58, 32'h306, 0, 4, 1, 1, 1, 0, 3'b101);
        tick; gnt = 1;
        tick; gnt = 0; rvalid = 1; rdata = 32'h80011234;
        tick; rvalid = 0; clr;
        check("lhu_rdata", wb_rdata, 32'h00008001);

        // SB 0x101
        set_op(1, 32'h5C, 32'h101, 32'h12345678, 0, 0, 0, 0, 1, 3'b000);
        tick;
        check("sb_be", be, 4'b0010);
        check("sb_wdata", wdata, 32'h78787878);
        gnt = 1;
        tick; gnt = 0; clr;
        check("sb_en", wb_en, 1);

        // LW at 0x101
        set_op(1, 32'h60, 32'h101, 0, 6, 1, 1, 1, 0, 3'b010);
`ifdef MEM_MISALIGN_TRAP_EN
        tick; clr;
        check("mis_flag", misal, 1);
        check("mis_req", req, 0);
        check("mis_en", wb_en, 1);
        check("mis_rw", wb_rw, 0);
        tick;
        check("mis_flag_drop", misal, 0);
`else
        tick;
        check("nomis_req", req, 1);
        check("nomis_addr", addr, 32'h100);
        check("nomis_flag", misal, 0);
        gnt = 1;
        tick; gnt = 0; rvalid = 1; rdata = 32'h01020304;
        tick; rvalid = 0; clr;
        check("nomis_rdata", wb_rdata, 32'h01020304);
        check("nomis_rw", wb_rw, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
